mul_arbiter: RTL

//  Shares one booth_multiplier between NUM_REQ requesters. Round-robin grant, one operation in flight,

---
 rtl/mul_arb_pkg.sv | 19 +
 rtl/mul_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mul_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arbiter shared definitions: FSM state codes and default widths.
// Imported by mul_arbiter and rr_arbiter.
package mul_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DW_DEF      = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  function automatic int res_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at/after ptr.
// Ports: req_i (request vector), ptr_i (start index), gnt_o (one-hot),
//        id_o (granted index), any_o (some request present).
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     id_o,
  output logic               any_o
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      idx = sum[IDW-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one multiplier between NUM_REQ requesters,
// round-robin, one op in flight. Optional macro: MUL_ARB_PERF_EN.
// Ports: req_* (requester operand handshake), rsp_* (result handshake),
//        mul_* (multiplier operand/result handshakes),
//        perf_ops_o/perf_busy_o (only with MUL_ARB_PERF_EN).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DW      = DW_DEF,
  localparam int IDW    = $clog2(NUM_REQ),
  localparam int RW     = 2 * DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MUL_ARB_PERF_EN
  output logic [31:0]           perf_ops_o,
  output logic [31:0]           perf_busy_o,
`endif
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*DW-1:0] req_data1_i,
  input  logic [NUM_REQ*DW-1:0] req_data2_i,
  input  logic [NUM_REQ-1:0]    req_signed_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [RW-1:0]         rsp_res_o,
  output logic                  mul_valid_o,
  input  logic                  mul_ready_i,
  output logic [DW-1:0]         mul_data1_o,
  output logic [DW-1:0]         mul_data2_o,
  output logic                  mul_signal_o,
  input  logic                  mul_valid_i,
  output logic                  mul_ready_o,
  input  logic [RW-1:0]         mul_res_i
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [DW-1:0]  d1_q, d1_d;
  logic [DW-1:0]  d2_q, d2_d;
  logic           sg_q, sg_d;
  logic [RW-1:0]  res_q, res_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gid;
  logic               any;
  logic               rsp_hs;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gid),
    .any_o (any)
  );

  assign rsp_hs = (state_q == S_RESP) && rsp_ready_i[owner_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    sg_d    = sg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          state_d = S_ISSUE;
          owner_d = gid;
          if (gid == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gid + IDW'(1);
          end
          for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
              d1_d = req_data1_i[k*DW +: DW];
              d2_d = req_data2_i[k*DW +: DW];
              sg_d = req_signed_i[k];
            end
          end
        end
      end
      S_ISSUE: begin
        if (mul_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid_i) begin
          res_d   = mul_res_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      sg_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      sg_q    <= sg_d;
      res_q   <= res_d;
    end
  end

  // Grant is combinational from IDLE; masked so reset drives it low.
  assign req_ready_o  = (rst_n && state_q == S_IDLE) ? gnt : '0;
  assign mul_valid_o  = (state_q == S_ISSUE);
  assign mul_data1_o  = d1_q;
  assign mul_data2_o  = d2_q;
  assign mul_signal_o = sg_q;
  assign mul_ready_o  = (state_q == S_WAIT);
  assign rsp_valid_o  = (state_q == S_RESP) ?
                        (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_res_o    = res_q;

`ifdef MUL_ARB_PERF_EN
  logic [31:0] ops_q, ops_d;
  logic [31:0] busy_q, busy_d;

  always_comb begin
    ops_d  = ops_q;
    busy_d = busy_q;
    if (rsp_hs && ops_q != '1) ops_d = ops_q + 32'd1;
    if (state_q != S_IDLE && busy_q != '1) busy_d = busy_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q  <= '0;
      busy_q <= '0;
    end else begin
      ops_q  <= ops_d;
      busy_q <= busy_d;
    end
  end

  assign perf_ops_o  = ops_q;
  assign perf_busy_o = busy_q;
`endif

endmodule
